// File: rtl/servo_pkg.sv
// Shared definitions for the servo drive path (encoder and decoder).
//   SERVO_PULSE_MIN / SERVO_PULSE_MAX : pulse widths in ticks mapping to level 0 / full scale
//   dec_state_e                       : decoder FSM state encoding
//   width_to_level()                  : rounded width-to-level mapping, clamped to max_level
package servo_pkg;

  localparam int SERVO_PULSE_MIN = 5;
  localparam int SERVO_PULSE_MAX = 25;
  localparam int LEVEL_W         = 4;
  localparam int WIDTH_W         = 6;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    HIGH,
    LOW
  } dec_state_e;

  // Maps a width in ticks onto 0..max_level with round-half-up. Widths outside
  // [pulse_min, pulse_max] pin to the nearest end of the scale.
  function automatic logic [LEVEL_W-1:0] width_to_level(
    input logic [WIDTH_W-1:0] w,
    input logic [LEVEL_W-1:0] max_level,
    input int                 pulse_min,
    input int                 pulse_max
  );
    int span;
    int wi;
    int ml;
    int lvl;
    span = pulse_max - pulse_min;
    wi   = int'(w);
    ml   = int'(max_level);
    if (ml == 0 || wi < pulse_min) begin
      lvl = 0;
    end else if (wi > pulse_max) begin
      lvl = ml;
    end else begin
      lvl = ((wi - pulse_min) * ml + span / 2) / span;
      if (lvl > ml) lvl = ml;
    end
    return LEVEL_W'(lvl);
  endfunction

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Bundle between the PWM pin, the decoder and the speed display/control logic.
//   pwm_in      : raw servo PWM pin (asynchronous)
//   max_level   : full-scale level used for the mapping
//   speed_level : decoded level
//   pulse_width : last rounded width in ticks
//   meas_valid  : one-cycle measurement strobe
//   range_err   : last measurement out of range
//   signal_lost : sticky loss-of-signal flag
// master = decoder side, slave = consumer / pin driver side.
interface servo_pwm_decoder_if;
  import servo_pkg::*;

  logic               pwm_in;
  logic [LEVEL_W-1:0] max_level;
  logic [LEVEL_W-1:0] speed_level;
  logic [WIDTH_W-1:0] pulse_width;
  logic               meas_valid;
  logic               range_err;
  logic               signal_lost;

  modport master (
    input  pwm_in, max_level,
    output speed_level, pulse_width, meas_valid, range_err, signal_lost
  );

  modport slave (
    output pwm_in, max_level,
    input  speed_level, pulse_width, meas_valid, range_err, signal_lost
  );

endinterface

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the PWM pin followed by a previous-sample register
// for edge detection.
//   clk, rst  : system clock, synchronous active-low reset
//   din       : asynchronous input
//   sync_lvl  : synchronized level
//   sync_vld  : high once the synchronized level has really come from the pin
//               (the reset zeros have been flushed out of the chain)
//   rise/fall : one-cycle edge pulses, two cycles after the pin edge
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_lvl,
  output logic sync_vld,
  output logic rise,
  output logic fall
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
    fill_d = {fill_q[0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      fill_q <= 2'b00;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fill_q <= fill_d;
    end
  end

  assign sync_lvl = sync_q;
  assign sync_vld = fill_q[1];
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receive side: measures the high time of the incoming pulse in
// ticks of TICK_DIV clocks and maps it onto a speed level 0..max_level.
//   clk, rst : system clock, synchronous active-low reset
//   bus      : servo_pwm_decoder_if.master (pwm_in, max_level in;
//              speed_level, pulse_width, meas_valid, range_err, signal_lost out)
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int PULSE_MIN  = SERVO_PULSE_MIN,
  parameter int PULSE_MAX  = SERVO_PULSE_MAX,
  parameter int TICK_DIV   = 1000,
  parameter int PERIOD_MAX = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  servo_pwm_decoder_if.master  bus
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PER_W   = $clog2(PERIOD_MAX + 1);

  logic sync_lvl, sync_vld, rise, fall;

  pwm_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (bus.pwm_in),
    .sync_lvl (sync_lvl),
    .sync_vld (sync_vld),
    .rise     (rise),
    .fall     (fall)
  );

  dec_state_e         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [LEVEL_W-1:0] speed_q, speed_d;
  logic [WIDTH_W-1:0] pw_q, pw_d;
  logic               mv_q, mv_d;
  logic               rerr_q, rerr_d;
  logic               lost_q, lost_d;

  logic               tick;
  logic               timeout;
  logic [PRESC_W-1:0] presc_nxt;
  logic [WIDTH_W-1:0] width_inc;
  logic [PER_W-1:0]   per_inc;
  logic [WIDTH_W:0]   w_round;
  logic [WIDTH_W-1:0] w_sat;

  always_comb begin
    tick      = (presc_q == PRESC_W'(TICK_DIV - 1));
    timeout   = (per_q == PER_W'(PERIOD_MAX));
    presc_nxt = tick ? '0 : presc_q + PRESC_W'(1);
    width_inc = (tick && width_q != '1) ? width_q + WIDTH_W'(1) : width_q;
    per_inc   = tick ? per_q + PER_W'(1) : per_q;
    // The fall cycle's own clock is counted (the rise cycle is not), so the
    // measured high time is exactly the number of high samples; the half-tick
    // remainder then rounds to the nearest tick.
    w_round   = {1'b0, width_inc} +
                {{WIDTH_W{1'b0}}, (presc_nxt >= PRESC_W'(TICK_DIV / 2))};
    w_sat     = w_round[WIDTH_W] ? '1 : w_round[WIDTH_W-1:0];

    state_d = state_q;
    presc_d = rise ? '0 : presc_nxt;
    width_d = width_q;
    per_d   = per_q;
    speed_d = speed_q;
    pw_d    = pw_q;
    mv_d    = 1'b0;
    rerr_d  = rerr_q;
    lost_d  = lost_q;

    unique case (state_q)
      ARM: begin
        width_d = '0;
        per_d   = '0;
        if (sync_vld && !sync_lvl) state_d = IDLE;
      end
      IDLE: begin
        if (timeout) begin
          lost_d  = 1'b1;
          speed_d = '0;
          state_d = ARM;
        end else if (rise) begin
          width_d = '0;
          per_d   = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        width_d = width_inc;
        per_d   = per_inc;
        // A saturated width means the pin is stuck high; ARM then waits for a
        // low level so the stuck pulse is never reported as a measurement.
        if (timeout || width_q == '1) begin
          lost_d  = 1'b1;
          speed_d = '0;
          state_d = ARM;
        end else if (fall) begin
          pw_d    = w_sat;
          mv_d    = 1'b1;
          rerr_d  = (w_sat < WIDTH_W'(PULSE_MIN)) || (w_sat > WIDTH_W'(PULSE_MAX));
          speed_d = width_to_level(w_sat, bus.max_level, PULSE_MIN, PULSE_MAX);
          lost_d  = 1'b0;
          state_d = LOW;
        end
      end
      LOW: begin
        per_d = per_inc;
        if (timeout) begin
          lost_d  = 1'b1;
          speed_d = '0;
          state_d = ARM;
        end else if (rise) begin
          width_d = '0;
          per_d   = '0;
          state_d = HIGH;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARM;
      presc_q <= '0;
      width_q <= '0;
      per_q   <= '0;
      speed_q <= '0;
      pw_q    <= '0;
      mv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      width_q <= width_d;
      per_q   <= per_d;
      speed_q <= speed_d;
      pw_q    <= pw_d;
      mv_q    <= mv_d;
      rerr_q  <= rerr_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.speed_level = speed_q;
  assign bus.pulse_width = pw_q;
  assign bus.meas_valid  = mv_q;
  assign bus.range_err   = rerr_q;
  assign bus.signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with TICK_DIV=4: table of single pulses,
// hand-written loss / stuck-high / mid-pulse reset sequences, and random
// pulses checked against an arithmetic model of the decoding rules.
module tb_servo_pwm_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  servo_pwm_decoder_if bus();

  servo_pwm_decoder #(
    .PULSE_MIN  (5),
    .PULSE_MAX  (25),
    .TICK_DIV   (4),
    .PERIOD_MAX (200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int hi;
    int ml;
    int exp_w;
    int exp_lvl;
    int exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: high time in clocks rounded half-up to ticks of 4 clocks.
  function automatic int model_w(input int hi);
    int w;
    w = (hi + 2) / 4;
    return (w > 63) ? 63 : w;
  endfunction

  function automatic int model_lvl(input int w, input int ml);
    int l;
    if (ml == 0 || w < 5) return 0;
    if (w > 25) return ml;
    l = ((w - 5) * ml + 10) / 20;
    return (l > ml) ? ml : l;
  endfunction

  function automatic int model_err(input int w);
    return (w < 5 || w > 25) ? 1 : 0;
  endfunction

  // One high pulse of hi clocks followed by lo low clocks. Reports the cycle
  // (after the fall) of the first meas_valid, the strobe count and the outputs
  // captured with the strobe.
  task automatic pulse(input int hi, input int lo, input int ml,
                       output int first, output int cnt, output int pw,
                       output int lvl, output int rerr, output int lost);
    first = -1; cnt = 0; pw = -1; lvl = -1; rerr = -1; lost = -1;
    bus.max_level = 4'(ml);
    @(posedge clk); #1;
    bus.pwm_in = 1'b1;
    repeat (hi) begin
      @(posedge clk); #1;
      if (bus.meas_valid) cnt++;
    end
    bus.pwm_in = 1'b0;
    for (int c = 1; c <= lo; c++) begin
      @(posedge clk); #1;
      if (bus.meas_valid) begin
        cnt++;
        if (first < 0) begin
          first = c;
          pw    = int'(bus.pulse_width);
          lvl   = int'(bus.speed_level);
          rerr  = int'(bus.range_err);
          lost  = int'(bus.signal_lost);
        end
      end
    end
  endtask

  task automatic check_pulse(input string tag, input int hi, input int lo, input int ml,
                             input int ew, input int el, input int ee);
    int first, cnt, pw, lvl, rerr, lost;
    pulse(hi, lo, ml, first, cnt, pw, lvl, rerr, lost);
    chk({tag, ".strobes"},  cnt,  1);
    chk({tag, ".latency"},  first, 3);
    chk({tag, ".width"},    pw,   ew);
    chk({tag, ".level"},    lvl,  el);
    chk({tag, ".rerr"},     rerr, ee);
    chk({tag, ".lost"},     lost, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, ".speed"}, int'(bus.speed_level), 0);
    chk({tag, ".width"}, int'(bus.pulse_width), 0);
    chk({tag, ".mv"},    int'(bus.meas_valid),  0);
    chk({tag, ".rerr"},  int'(bus.range_err),   0);
    chk({tag, ".lost"},  int'(bus.signal_lost), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first_lost, hi, lo, ml, w;
    vecs[0]  = '{60,  10, 15, 5,  0};
    vecs[1]  = '{20,  10, 5,  0,  0};
    vecs[2]  = '{100, 10, 25, 10, 0};
    vecs[3]  = '{62,  10, 16, 6,  0};
    vecs[4]  = '{120, 10, 30, 10, 1};
    vecs[5]  = '{12,  10, 3,  0,  1};
    vecs[6]  = '{60,  0,  15, 0,  0};
    vecs[7]  = '{62,  15, 16, 8,  0};
    vecs[8]  = '{24,  10, 6,  1,  0};
    vecs[9]  = '{18,  10, 5,  0,  0};
    vecs[10] = '{102, 10, 26, 10, 1};

    bus.pwm_in    = 1'b0;
    bus.max_level = 4'd10;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Table of single pulses
    foreach (vecs[i]) begin
      check_pulse($sformatf("vec%0d", i), vecs[i].hi, 300, vecs[i].ml,
                  vecs[i].exp_w, vecs[i].exp_lvl, vecs[i].exp_err);
    end

    // Loss of signal after a long low period, then recovery
    check_pulse("loss_pre", 60, 600, 10, 15, 5, 0);
    chk("loss_not_early", int'(bus.signal_lost), 0);
    first_lost = -1;
    cnt = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (bus.meas_valid) cnt++;
      if (bus.signal_lost && first_lost < 0) first_lost = c;
    end
    chk("loss_flag",    int'(bus.signal_lost), 1);
    chk("loss_level",   int'(bus.speed_level), 0);
    chk("loss_strobes", cnt, 0);
    chk("loss_timing_in_window", int'(first_lost >= 142 && first_lost <= 146), 1);
    check_pulse("loss_recover", 60, 300, 10, 15, 5, 0);
    chk("loss_cleared", int'(bus.signal_lost), 0);

    // Pin stuck high
    cnt = 0;
    @(posedge clk); #1;
    bus.pwm_in = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (bus.meas_valid) cnt++;
    end
    chk("stuck_lost",  int'(bus.signal_lost), 1);
    chk("stuck_level", int'(bus.speed_level), 0);
    bus.pwm_in = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.meas_valid) cnt++;
    end
    chk("stuck_strobes", cnt, 0);
    check_pulse("stuck_recover", 62, 300, 10, 16, 6, 0);

    // Reset in the middle of a high pulse
    cnt = 0;
    @(posedge clk); #1;
    bus.pwm_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check_outputs_zero("midrst");
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.meas_valid) cnt++;
    end
    bus.pwm_in = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.meas_valid) cnt++;
    end
    chk("midrst_strobes", cnt, 0);
    check_pulse("midrst_next", 60, 300, 10, 15, 5, 0);

    // Random pulses against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      hi = int'($urandom_range(4, 140));
      lo = int'($urandom_range(12, 150));
      ml = int'($urandom_range(0, 15));
      w  = model_w(hi);
      check_pulse($sformatf("rnd%0d_hi%0d_ml%0d", i, hi, ml), hi, lo, ml,
                  w, model_lvl(w, ml), model_err(w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
